sipo_deserializer: RTL and testbench

- Serial-to-parallel receiver; the receive end of the team's PISO serial link.
- Accepts an MSB-first bit stream, qualified by a bit strobe and a frame-start marker, and assembles WIDTH-bit words.
- Presents each word on a valid/ready output register with sticky overrun and framing error flags.
- Sits between the serial link pins and the consuming parallel datapath.

---
 rtl/sipo_pkg.sv | 26 ++
 rtl/sipo_deserializer_if.sv | 41 ++++
 rtl/sipo_out_reg.sv | 92 +++++++++
 rtl/sipo_deserializer.sv | 161 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// ----------------------------------------------------------------------------
// sipo_pkg
// Shared types and constants for the SIPO deserializer (receive end of the
// PISO serial link).
//   sipo_state_e    : receiver FSM states (PARITY used only when the build
//                     defines SIPO_PARITY_EN)
//   SIPO_WIDTH_DEF  : default data bits per word
//   sipo_cnt_width  : width of the bit counter for a given word width
// ----------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  localparam int SIPO_WIDTH_DEF = 4;

  // The counter must be able to hold WIDTH itself (reached before the
  // parity bit when the parity option is built in).
  function automatic int sipo_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// ----------------------------------------------------------------------------
// sipo_deserializer_if
// Serial link input side and parallel word output side of the deserializer.
//   Serial_In, Bit_Valid, Frame_Start : serial bit stream from the link
//   Out_Ready, Err_Clr                : consumer handshake / sticky clear
//   Parallel_Out, Out_Valid           : assembled word and its valid flag
//   Busy, Overrun, Frame_Err,
//   Parity_Err                        : receiver status
// Modports:
//   slave  : the deserializer
//   master : link source + parallel consumer (environment side)
// ----------------------------------------------------------------------------
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
);

  logic             Serial_In;
  logic             Bit_Valid;
  logic             Frame_Start;
  logic             Out_Ready;
  logic             Err_Clr;
  logic [WIDTH-1:0] Parallel_Out;
  logic             Out_Valid;
  logic             Busy;
  logic             Overrun;
  logic             Frame_Err;
  logic             Parity_Err;

  modport slave (
    input  Serial_In, Bit_Valid, Frame_Start, Out_Ready, Err_Clr,
    output Parallel_Out, Out_Valid, Busy, Overrun, Frame_Err, Parity_Err
  );

  modport master (
    output Serial_In, Bit_Valid, Frame_Start, Out_Ready, Err_Clr,
    input  Parallel_Out, Out_Valid, Busy, Overrun, Frame_Err, Parity_Err
  );

endinterface

// File: rtl/sipo_out_reg.sv
// ----------------------------------------------------------------------------
// sipo_out_reg
// Output holding register of the deserializer with valid/ready handshake and
// the sticky error flags.
//   Clk, Rst_n     : clock, async active-low reset
//   word_done      : a complete word is offered this cycle
//   word           : the offered word
//   word_par_err   : parity result belonging to the offered word
//   frame_err_set  : a frame was aborted this cycle
//   out_ready      : consumer takes parallel_out when out_valid=1
//   err_clr        : clears overrun and frame_err (a same-cycle set wins)
//   parallel_out, out_valid, overrun, frame_err, parity_err : registered outputs
// ----------------------------------------------------------------------------
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
  input  logic             word_par_err,
  input  logic             frame_err_set,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             par_err_r;
  logic             overrun_r;
  logic             frame_err_r;
  logic             accept_s;
  logic             overrun_set_s;

  // Register is free when empty or being drained on this same edge.
  always_comb begin
    accept_s      = (!valid_r) || out_ready;
    overrun_set_s = word_done && !accept_s;
  end

  // Holding register: load on accept, otherwise keep the unconsumed word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_r    <= {WIDTH{1'b0}};
      par_err_r <= 1'b0;
      valid_r   <= 1'b0;
    end else if (word_done && accept_s) begin
      data_r    <= word;
      par_err_r <= word_par_err;
      valid_r   <= 1'b1;
    end else if (!word_done && out_ready) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

  // Sticky error flags; a set on the same edge as a clear takes priority.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (err_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (frame_err_set) begin
        frame_err_r <= 1'b1;
      end else if (err_clr) begin
        frame_err_r <= 1'b0;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  assign parallel_out = data_r;
  assign out_valid    = valid_r;
  assign overrun      = overrun_r;
  assign frame_err    = frame_err_r;
  assign parity_err   = par_err_r;

endmodule

// File: rtl/sipo_deserializer.sv
// ----------------------------------------------------------------------------
// sipo_deserializer
// Serial-to-parallel receiver: assembles MSB-first WIDTH-bit words from a
// strobed bit stream with a frame-start marker.
//   Clk   : clock, all state updates on posedge
//   Rst_n : asynchronous active-low reset (discards any partial word)
//   bus   : sipo_deserializer_if.slave (serial inputs, word output, status)
// Build option:
//   SIPO_PARITY_EN : an even-parity bit follows every word; the word is
//                    delivered on the parity-bit edge with Parity_Err.
//                    Without it Parity_Err is constant 0.
// ----------------------------------------------------------------------------
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic                Clk,
  input  logic                Rst_n,
  sipo_deserializer_if.slave  bus
);

  localparam int              CNT_W    = sipo_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sipo_state_e      state_r;
  sipo_state_e      state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_nxt_s;
  logic             busy_r;
  logic [WIDTH-1:0] first_s;
  logic [WIDTH-1:0] shifted_s;
  logic             done_s;
  logic [WIDTH-1:0] word_s;
  logic             par_err_s;
  logic             frame_err_set_s;

  // Odd number of ones across word and parity bit means even parity failed.
  function automatic logic parity_fail(input logic [WIDTH-1:0] w, input logic p);
    return ^{w, p};
  endfunction

  // Next state, counter, shift register and word-completion decode.
  always_comb begin
    first_s         = {{(WIDTH-1){1'b0}}, bus.Serial_In};
    shifted_s       = {shreg_r[WIDTH-2:0], bus.Serial_In};
    state_nxt_s     = state_r;
    count_nxt_s     = count_r;
    shreg_nxt_s     = shreg_r;
    done_s          = 1'b0;
    word_s          = shifted_s;
    par_err_s       = 1'b0;
    frame_err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Bit_Valid && bus.Frame_Start) begin
          shreg_nxt_s = first_s;
          count_nxt_s = CNT_W'(1);
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.Bit_Valid && bus.Frame_Start) begin
          // Abort the partial word; this bit is the MSB of a new one.
          frame_err_set_s = 1'b1;
          shreg_nxt_s     = first_s;
          count_nxt_s     = CNT_W'(1);
        end else if (bus.Bit_Valid && (count_r == LAST_CNT)) begin
          shreg_nxt_s = shifted_s;
`ifdef SIPO_PARITY_EN
          count_nxt_s = count_r + CNT_W'(1);
          state_nxt_s = PARITY;
`else
          count_nxt_s = CNT_W'(0);
          done_s      = 1'b1;
          state_nxt_s = IDLE;
`endif
        end else if (bus.Bit_Valid) begin
          shreg_nxt_s = shifted_s;
          count_nxt_s = count_r + CNT_W'(1);
        end else begin
          state_nxt_s = SHIFT;
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        word_s = shreg_r;
        if (bus.Bit_Valid && bus.Frame_Start) begin
          frame_err_set_s = 1'b1;
          shreg_nxt_s     = first_s;
          count_nxt_s     = CNT_W'(1);
          state_nxt_s     = SHIFT;
        end else if (bus.Bit_Valid) begin
          done_s      = 1'b1;
          par_err_s   = parity_fail(shreg_r, bus.Serial_In);
          count_nxt_s = CNT_W'(0);
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = CNT_W'(0);
        shreg_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // FSM, counter and shift register state; Busy registered from next state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      count_r <= CNT_W'(0);
      shreg_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      shreg_r <= shreg_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  logic [WIDTH-1:0] pout_s;
  logic             valid_s;
  logic             overrun_s;
  logic             frame_err_s;
  logic             parity_err_s;

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .word_done     (done_s),
    .word          (word_s),
    .word_par_err  (par_err_s),
    .frame_err_set (frame_err_set_s),
    .out_ready     (bus.Out_Ready),
    .err_clr       (bus.Err_Clr),
    .parallel_out  (pout_s),
    .out_valid     (valid_s),
    .overrun       (overrun_s),
    .frame_err     (frame_err_s),
    .parity_err    (parity_err_s)
  );

  assign bus.Parallel_Out = pout_s;
  assign bus.Out_Valid    = valid_s;
  assign bus.Busy         = busy_r;
  assign bus.Overrun      = overrun_s;
  assign bus.Frame_Err    = frame_err_s;
  assign bus.Parity_Err   = parity_err_s;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ----------------------------------------------------------------------------
// tb_sipo_deserializer
// Self-checking bench for sipo_deserializer (WIDTH=4). Directed scenarios
// followed by random bit streams, all compared every cycle against a
// queue-based reference model of the receiver. Honours SIPO_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;

  always #5 Clk = ~Clk;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int           m_q[$];
  bit           m_act;
  logic [W-1:0] m_pout;
  bit           m_valid;
  bit           m_ovr;
  bit           m_ferr;
  bit           m_perr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_act   = 1'b0;
    m_pout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endfunction

  // One clock edge of the receiver described at frame level.
  function automatic void model_edge(bit bv, bit fs, bit si, bit rdy, bit clr);
    bit done = 1'b0;
    bit ovr_set = 1'b0;
    bit ferr_set = 1'b0;
    int word = 0;
    bit par = 1'b0;
    if (bv) begin
      if (fs) begin
        if (m_act) ferr_set = 1'b1;
        m_q.delete();
        m_q.push_back(int'(si));
        m_act = 1'b1;
      end else if (m_act) begin
        m_q.push_back(int'(si));
      end
    end
    if (m_act && m_q.size() == FB) begin
      for (int i = 0; i < W; i++) word = word * 2 + m_q[i];
      foreach (m_q[i]) par = par ^ m_q[i][0];
      done  = 1'b1;
      m_act = 1'b0;
      m_q.delete();
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_pout  = word[W-1:0];
`ifdef SIPO_PARITY_EN
        m_perr  = par;
`else
        m_perr  = 1'b0;
`endif
        m_valid = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    m_ovr  = ovr_set  ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_ferr = ferr_set ? 1'b1 : (clr ? 1'b0 : m_ferr);
  endfunction

  task automatic check_all();
    check_val("parallel_out", 32'(bus.Parallel_Out), 32'(m_pout));
    check_val("out_valid",    32'(bus.Out_Valid),    32'(m_valid));
    check_val("busy",         32'(bus.Busy),         32'(m_act));
    check_val("overrun",      32'(bus.Overrun),      32'(m_ovr));
    check_val("frame_err",    32'(bus.Frame_Err),    32'(m_ferr));
    check_val("parity_err",   32'(bus.Parity_Err),   32'(m_perr));
  endtask

  // Drive one cycle of inputs (called at negedge), clock it, check at negedge.
  task automatic step(input bit bv, input bit fs, input bit si, input bit rdy, input bit clr);
    bus.Bit_Valid   = bv;
    bus.Frame_Start = fs;
    bus.Serial_In   = si;
    bus.Out_Ready   = rdy;
    bus.Err_Clr     = clr;
    @(posedge Clk);
    model_edge(bv, fs, si, rdy, clr);
    @(negedge Clk);
    check_all();
  endtask

  // Full frame MSB first, optional idle gaps between bits, parity bit if built.
  task automatic send_frame(input logic [W-1:0] w, input bit rdy, input int gap, input bit par_flip);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, w[W-1-i], rdy, 1'b0);
      if (i < W - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      end
    end
`ifdef SIPO_PARITY_EN
    step(1'b1, 1'b0, (^w) ^ par_flip, rdy, 1'b0);
`else
    if (par_flip) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
`endif
  endtask

  initial begin
    bus.Serial_In   = 1'b0;
    bus.Bit_Valid   = 1'b0;
    bus.Frame_Start = 1'b0;
    bus.Out_Ready   = 1'b0;
    bus.Err_Clr     = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    Rst_n = 1'b1;

    // Back-to-back frame, consumer ready: word visible one cycle, then drained.
    send_frame(4'b1011, 1'b1, 0, 1'b0);
    check_val("t1_data", 32'(bus.Parallel_Out), 32'hB);
    check_val("t1_valid", 32'(bus.Out_Valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t1_valid_drop", 32'(bus.Out_Valid), 32'h0);

    // Same frame with two-cycle strobe gaps.
    send_frame(4'b1011, 1'b1, 2, 1'b0);
    check_val("t2_data", 32'(bus.Parallel_Out), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Consumer stalled: second word dropped, overrun raised, then cleared.
    send_frame(4'hA, 1'b0, 0, 1'b0);
    send_frame(4'h5, 1'b0, 0, 1'b0);
    check_val("t3_hold", 32'(bus.Parallel_Out), 32'hA);
    check_val("t3_overrun", 32'(bus.Overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t3_drain", 32'(bus.Out_Valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("t3_clr", 32'(bus.Overrun), 32'h0);

    // Frame restarted mid-word.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b1, 0, 1'b0);
    check_val("t4_ferr", 32'(bus.Frame_Err), 32'h1);
    check_val("t4_data", 32'(bus.Parallel_Out), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-frame, then a clean frame.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    model_reset();
    check_val("t5_rst_valid", 32'(bus.Out_Valid), 32'h0);
    check_val("t5_rst_busy", 32'(bus.Busy), 32'h0);
    check_all();
    @(negedge Clk);
    Rst_n = 1'b1;
    send_frame(4'h9, 1'b1, 0, 1'b0);
    check_val("t5_data", 32'(bus.Parallel_Out), 32'h9);
    check_val("t5_valid", 32'(bus.Out_Valid), 32'h1);

`ifdef SIPO_PARITY_EN
    // Word held back until the parity bit; good then bad parity.
    for (int i = 0; i < W; i++) step(1'b1, i == 0, (i != 1), 1'b1, 1'b0);
    check_val("t6_wait", 32'(bus.Out_Valid), 32'h0);
    check_val("t6_busy", 32'(bus.Busy), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("t6_good_valid", 32'(bus.Out_Valid), 32'h1);
    check_val("t6_good_perr", 32'(bus.Parity_Err), 32'h0);
    send_frame(4'b1011, 1'b1, 0, 1'b1);
    check_val("t6_bad_perr", 32'(bus.Parity_Err), 32'h1);
    check_val("t6_bad_data", 32'(bus.Parallel_Out), 32'hB);
`endif

    // Random streams against the model.
    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 4) != 0, ($urandom % 6) == 0, $urandom % 2 == 1,
           ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
